// File: rtl/union_find_ops.sv
// union_find_ops: tagged UNION / CONNECTED / SIZE_OF engine over a union-by-size forest.
// Define UNION_FIND_PATH_COMPRESS_EN to add a path-compression pass after each find.

module union_find_ops #(
    parameter int MAX_NODE_COUNT = 2048,
    parameter int HOPS_PER_CYCLE = 4,
    parameter int TAG_WIDTH      = 8,
    localparam int IDX_W         = $clog2(MAX_NODE_COUNT),
    localparam int SIZE_W        = $clog2(MAX_NODE_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [IDX_W-1:0]     in_u,
    input  logic [IDX_W-1:0]     in_v,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_error,
    output logic                 out_merged,
    output logic                 out_connected,
    output logic [IDX_W-1:0]     out_root,
    output logic [SIZE_W-1:0]    out_size,
    output logic [SIZE_W-1:0]    comp_count,
    output logic [SIZE_W-1:0]    max_size
);

    localparam logic [1:0] OP_UNION = 2'd0;
    localparam logic [1:0] OP_SIZE  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;
    localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(MAX_NODE_COUNT - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_FIND_U,
        S_FIND_V,
        S_MERGE,
`ifdef UNION_FIND_PATH_COMPRESS_EN
        S_COMP_U,
        S_COMP_V,
`endif
        S_RESPOND
    } state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0]     init_q, init_d;
    logic [1:0]           op_q, op_d;
    logic [IDX_W-1:0]     v_q, v_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [IDX_W-1:0]     ru_q, ru_d;
    logic [IDX_W-1:0]     rv_q, rv_d;
    logic                 pend_q, pend_d;
    logic [IDX_W-1:0]     pend_addr_q, pend_addr_d;
    logic [IDX_W-1:0]     pend_par_q, pend_par_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 err_q, err_d;
    logic                 merged_q, merged_d;
    logic                 conn_q, conn_d;
    logic [IDX_W-1:0]     root_q, root_d;
    logic [SIZE_W-1:0]    size_q, size_d;
    logic [SIZE_W-1:0]    comp_q, comp_d;
    logic [SIZE_W-1:0]    max_q, max_d;
`ifdef UNION_FIND_PATH_COMPRESS_EN
    logic [IDX_W-1:0]     u_q, u_d;
    logic [IDX_W-1:0]     cur_par;
`endif

    // Node store: payload is the parent index for non-roots, the set size for roots.
    logic                 node_root_q [MAX_NODE_COUNT];
    logic [SIZE_W-1:0]    node_pay_q  [MAX_NODE_COUNT];
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_addr;
    logic                 wr_root;
    logic [SIZE_W-1:0]    wr_pay;

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            node_root_q[wr_addr] <= wr_root;
            node_pay_q[wr_addr]  <= wr_pay;
        end
    end

    // Operand range checks vanish when every encodable index is a real node.
    logic u_oob, v_oob, bad_cmd;
    generate
        if (MAX_NODE_COUNT == (1 << IDX_W)) begin : g_full_range
            assign u_oob = 1'b0;
            assign v_oob = 1'b0;
        end else begin : g_part_range
            assign u_oob = (in_u > LAST_NODE);
            assign v_oob = (in_v > LAST_NODE);
        end
    endgenerate
    assign bad_cmd = (in_op == OP_RSVD) || u_oob || (v_oob && (in_op != OP_SIZE));

    // Up to HOPS_PER_CYCLE parent links per cycle; a root maps to itself so the chain saturates.
    logic [IDX_W-1:0] hop [HOPS_PER_CYCLE+1];
    logic [IDX_W-1:0] hop_end;
    logic             hop_found;
    always_comb begin
        hop[0] = cur_q;
        for (int h = 0; h < HOPS_PER_CYCLE; h++) begin
            hop[h+1] = node_root_q[hop[h]] ? hop[h] : node_pay_q[hop[h]][IDX_W-1:0];
        end
    end
    assign hop_end   = hop[HOPS_PER_CYCLE];
    assign hop_found = node_root_q[hop_end];

    logic [SIZE_W-1:0] size_u, size_v, size_sum;
    logic              u_wins;
    logic [IDX_W-1:0]  win_root, lose_root;
    assign size_u    = node_pay_q[ru_q];
    assign size_v    = node_pay_q[rv_q];
    assign size_sum  = size_u + size_v;
    assign u_wins    = (size_u >= size_v);
    assign win_root  = u_wins ? ru_q : rv_q;
    assign lose_root = u_wins ? rv_q : ru_q;
`ifdef UNION_FIND_PATH_COMPRESS_EN
    assign cur_par   = node_pay_q[cur_q][IDX_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        op_d        = op_q;
        v_d         = v_q;
        cur_d       = cur_q;
        ru_d        = ru_q;
        rv_d        = rv_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_par_d  = pend_par_q;
        tag_d       = tag_q;
        err_d       = err_q;
        merged_d    = merged_q;
        conn_d      = conn_q;
        root_d      = root_q;
        size_d      = size_q;
        comp_d      = comp_q;
        max_d       = max_q;
`ifdef UNION_FIND_PATH_COMPRESS_EN
        u_d         = u_q;
`endif
        wr_en       = 1'b0;
        wr_addr     = cur_q;
        wr_root     = 1'b0;
        wr_pay      = '0;
        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_q;
                wr_root = 1'b1;
                wr_pay  = SIZE_W'(1);
                init_d  = init_q + IDX_W'(1);
                if (init_q == LAST_NODE) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (in_valid) begin
                    op_d     = in_op;
                    v_d      = in_v;
                    cur_d    = in_u;
`ifdef UNION_FIND_PATH_COMPRESS_EN
                    u_d      = in_u;
`endif
                    tag_d    = in_tag;
                    err_d    = bad_cmd;
                    merged_d = 1'b0;
                    conn_d   = 1'b0;
                    root_d   = '0;
                    size_d   = '0;
                    state_d  = bad_cmd ? S_RESPOND : S_FIND_U;
                end
            end
            S_FIND_U: begin
                if (hop_found) begin
                    ru_d = hop_end;
`ifdef UNION_FIND_PATH_COMPRESS_EN
                    cur_d   = u_q;
                    state_d = S_COMP_U;
`else
                    if (op_q == OP_SIZE) begin
                        rv_d    = hop_end;
                        state_d = S_MERGE;
                    end else begin
                        cur_d   = v_q;
                        state_d = S_FIND_V;
                    end
`endif
                end else begin
                    cur_d = hop_end;
                end
            end
`ifdef UNION_FIND_PATH_COMPRESS_EN
            S_COMP_U: begin
                if (cur_q == ru_q) begin
                    if (op_q == OP_SIZE) begin
                        rv_d    = ru_q;
                        state_d = S_MERGE;
                    end else begin
                        cur_d   = v_q;
                        state_d = S_FIND_V;
                    end
                end else begin
                    wr_en  = 1'b1;
                    wr_pay = SIZE_W'(ru_q);
                    cur_d  = cur_par;
                end
            end
            S_COMP_V: begin
                if (cur_q == rv_q) begin
                    state_d = S_MERGE;
                end else begin
                    wr_en  = 1'b1;
                    wr_pay = SIZE_W'(rv_q);
                    cur_d  = cur_par;
                end
            end
`endif
            S_FIND_V: begin
                if (hop_found) begin
                    rv_d = hop_end;
`ifdef UNION_FIND_PATH_COMPRESS_EN
                    cur_d   = v_q;
                    state_d = S_COMP_V;
`else
                    state_d = S_MERGE;
`endif
                end else begin
                    cur_d = hop_end;
                end
            end
            S_MERGE: begin
                // Survivor size is written here; the loser's parent link goes out next cycle.
                if ((op_q == OP_UNION) && (ru_q != rv_q)) begin
                    wr_en       = 1'b1;
                    wr_addr     = win_root;
                    wr_root     = 1'b1;
                    wr_pay      = size_sum;
                    pend_d      = 1'b1;
                    pend_addr_d = lose_root;
                    pend_par_d  = win_root;
                    comp_d      = comp_q - SIZE_W'(1);
                    if (size_sum > max_q) max_d = size_sum;
                    merged_d    = 1'b1;
                    conn_d      = 1'b1;
                    root_d      = win_root;
                    size_d      = size_sum;
                end else begin
                    conn_d = (op_q == OP_UNION) || (ru_q == rv_q);
                    root_d = ru_q;
                    size_d = size_u;
                end
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                if (pend_q) begin
                    wr_en   = 1'b1;
                    wr_addr = pend_addr_q;
                    wr_pay  = SIZE_W'(pend_par_q);
                    pend_d  = 1'b0;
                end
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_q      <= '0;
            op_q        <= '0;
            v_q         <= '0;
            cur_q       <= '0;
            ru_q        <= '0;
            rv_q        <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_par_q  <= '0;
            tag_q       <= '0;
            err_q       <= 1'b0;
            merged_q    <= 1'b0;
            conn_q      <= 1'b0;
            root_q      <= '0;
            size_q      <= '0;
            comp_q      <= SIZE_W'(MAX_NODE_COUNT);
            max_q       <= SIZE_W'(1);
`ifdef UNION_FIND_PATH_COMPRESS_EN
            u_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            op_q        <= op_d;
            v_q         <= v_d;
            cur_q       <= cur_d;
            ru_q        <= ru_d;
            rv_q        <= rv_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_par_q  <= pend_par_d;
            tag_q       <= tag_d;
            err_q       <= err_d;
            merged_q    <= merged_d;
            conn_q      <= conn_d;
            root_q      <= root_d;
            size_q      <= size_d;
            comp_q      <= comp_d;
            max_q       <= max_d;
`ifdef UNION_FIND_PATH_COMPRESS_EN
            u_q         <= u_d;
`endif
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_RESPOND);
    assign out_tag       = tag_q;
    assign out_error     = err_q;
    assign out_merged    = merged_q;
    assign out_connected = conn_q;
    assign out_root      = root_q;
    assign out_size      = size_q;
    assign comp_count    = comp_q;
    assign max_size      = max_q;

endmodule

// File: tb/tb_union_find_ops.sv
// Bench for union_find_ops: 16-node/H=4 instance with a set-label model, 12-node/H=1 instance for depth, range and abort cases.

module tb_union_find_ops;

`ifdef UNION_FIND_PATH_COMPRESS_EN
    localparam int LAT_FRESH = 6;
    localparam int LAT_DEEP  = 9;
`else
    localparam int LAT_FRESH = 4;
    localparam int LAT_DEEP  = 5;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, sel, in_valid, out_ready;
    logic [1:0] in_op;
    logic [3:0] in_u, in_v;
    logic [7:0] in_tag;

    logic       a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_err, a_merged, a_conn;
    logic [7:0] a_tag;
    logic [3:0] a_root;
    logic [4:0] a_size, a_comp, a_max;
    logic       b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_err, b_merged, b_conn;
    logic [7:0] b_tag;
    logic [3:0] b_root;
    logic [3:0] b_size, b_comp, b_max;

    assign a_in_valid  = in_valid & ~sel;
    assign a_out_ready = out_ready & ~sel;
    assign b_in_valid  = in_valid & sel;
    assign b_out_ready = out_ready & sel;

    union_find_ops #(.MAX_NODE_COUNT(16), .HOPS_PER_CYCLE(4), .TAG_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(in_op),
        .in_u(in_u), .in_v(in_v), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_tag(a_tag), .out_error(a_err), .out_merged(a_merged), .out_connected(a_conn),
        .out_root(a_root), .out_size(a_size), .comp_count(a_comp), .max_size(a_max));

    union_find_ops #(.MAX_NODE_COUNT(12), .HOPS_PER_CYCLE(1), .TAG_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(in_op),
        .in_u(in_u), .in_v(in_v), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_tag(b_tag), .out_error(b_err), .out_merged(b_merged), .out_connected(b_conn),
        .out_root(b_root), .out_size(b_size), .comp_count(b_comp), .max_size(b_max));

    int nchk = 0, nfail = 0;
    int lat, r_err, r_merged, r_conn, r_root, r_size, r_tag, r_comp, r_max;

    // Reference model for dut_a: every node records the representative of its set.
    int m_rep [16];
    int m_comp, m_max;
    int e_err, e_merged, e_conn, e_root, e_size;

    function automatic int m_setsize(input int r);
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_rep[i] == r) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rep[i] = i;
        m_comp = 16;
        m_max  = 1;
    endtask

    task automatic model_cmd(input int op, input int u, input int v);
        int ru, rv, su, sv, win, lose;
        e_err = 0; e_merged = 0; e_conn = 0; e_root = 0; e_size = 0;
        if (op == 3) begin
            e_err = 1;
        end else begin
            ru = m_rep[u];
            rv = (op == 2) ? ru : m_rep[v];
            su = m_setsize(ru);
            sv = m_setsize(rv);
            if (op == 0 && ru != rv) begin
                win  = (su >= sv) ? ru : rv;
                lose = (su >= sv) ? rv : ru;
                for (int i = 0; i < 16; i++) if (m_rep[i] == lose) m_rep[i] = win;
                m_comp--;
                if (su + sv > m_max) m_max = su + sv;
                e_merged = 1; e_conn = 1; e_root = win; e_size = su + sv;
            end else begin
                e_conn = (op == 0 || ru == rv) ? 1 : 0;
                e_root = ru;
                e_size = su;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (((sel ? b_in_ready : a_in_ready) !== 1'b1) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if ((sel ? b_in_ready : a_in_ready) !== 1'b1) begin
            nchk++; nfail++;
            $display("FAIL in_ready timeout: got 0 required 1");
        end
    endtask

    task automatic issue(input int op, input int u, input int v, input int tag);
        wait_ready();
        if (!sel) model_cmd(op, u, v);
        in_op = 2'(op); in_u = 4'(u); in_v = 4'(v); in_tag = 8'(tag); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (((sel ? b_out_valid : a_out_valid) !== 1'b1) && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        if ((sel ? b_out_valid : a_out_valid) !== 1'b1) begin
            nchk++; nfail++;
            $display("FAIL out_valid timeout: op %0d got 0 required 1", op);
        end
        r_err    = sel ? int'(b_err)    : int'(a_err);
        r_merged = sel ? int'(b_merged) : int'(a_merged);
        r_conn   = sel ? int'(b_conn)   : int'(a_conn);
        r_root   = sel ? int'(b_root)   : int'(a_root);
        r_size   = sel ? int'(b_size)   : int'(a_size);
        r_tag    = sel ? int'(b_tag)    : int'(a_tag);
        r_comp   = sel ? int'(b_comp)   : int'(a_comp);
        r_max    = sel ? int'(b_max)    : int'(a_max);
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic cmd(input int op, input int u, input int v, input int tag);
        issue(op, u, v, tag);
        ack();
    endtask

    task automatic test_reset();
        int n = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nchk++; if (a_in_ready !== 1'b0) begin nfail++; $display("FAIL reset in_ready: got %b required 0", a_in_ready); end
        nchk++; if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL reset out_valid: got %b required 0", a_out_valid); end
        nchk++; if ({a_tag, a_err, a_merged, a_conn, a_root, a_size} !== '0) begin nfail++; $display("FAIL reset out fields: got tag %0h size %0d required 0", a_tag, a_size); end
        nchk++; if (a_comp !== 5'd16) begin nfail++; $display("FAIL reset comp_count: got %0d required 16", a_comp); end
        nchk++; if (a_max !== 5'd1) begin nfail++; $display("FAIL reset max_size: got %0d required 1", a_max); end
        rst_a = 1'b0; rst_b = 1'b0;
        model_reset();
        while (a_in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        nchk++; if (n != 16) begin nfail++; $display("FAIL init sweep length: got %0d required 16", n); end
        nchk++; if (b_in_ready !== 1'b1) begin nfail++; $display("FAIL small init done: got %b required 1", b_in_ready); end
        nchk++; if (a_comp !== 5'd16 || a_max !== 5'd1) begin nfail++; $display("FAIL post-init counts: got %0d/%0d required 16/1", a_comp, a_max); end
    endtask

    task automatic test_union_basic();
        sel = 1'b0;
        cmd(0, 0, 1, 8'h11);
        nchk++; if (lat != LAT_FRESH) begin nfail++; $display("FAIL fresh union latency: got %0d required %0d", lat, LAT_FRESH); end
        nchk++; if (r_merged != 1 || r_conn != 1) begin nfail++; $display("FAIL fresh union merged/conn: got %0d/%0d required 1/1", r_merged, r_conn); end
        nchk++; if (r_root != 0 || r_size != 2) begin nfail++; $display("FAIL fresh union root/size: got %0d/%0d required 0/2", r_root, r_size); end
        nchk++; if (r_tag != 8'h11) begin nfail++; $display("FAIL fresh union tag: got %0h required 11", r_tag); end
        nchk++; if (r_comp != 15 || r_max != 2) begin nfail++; $display("FAIL fresh union counts: got %0d/%0d required 15/2", r_comp, r_max); end
    endtask

    task automatic test_chain();
        cmd(0, 2, 3, 8'h21);
        cmd(0, 4, 2, 8'h22);
        nchk++; if (r_root != 2 || r_size != 3) begin nfail++; $display("FAIL smaller joins larger: got root %0d size %0d required 2/3", r_root, r_size); end
        cmd(0, 4, 0, 8'h23);
        nchk++; if (r_root != 2 || r_size != 5 || r_merged != 1) begin nfail++; $display("FAIL chain union: got root %0d size %0d merged %0d required 2/5/1", r_root, r_size, r_merged); end
        cmd(1, 3, 1, 8'h24);
        nchk++; if (r_conn != 1 || r_size != 5 || r_merged != 0) begin nfail++; $display("FAIL connected(3,1): got conn %0d size %0d merged %0d required 1/5/0", r_conn, r_size, r_merged); end
        nchk++; if (r_comp != 12 || r_max != 5) begin nfail++; $display("FAIL chain counts: got %0d/%0d required 12/5", r_comp, r_max); end
    endtask

    task automatic test_already_joined();
        cmd(0, 1, 3, 8'h31);
        nchk++; if (r_merged != 0 || r_conn != 1 || r_comp != 12) begin nfail++; $display("FAIL rejoin: got merged %0d conn %0d comp %0d required 0/1/12", r_merged, r_conn, r_comp); end
        cmd(0, 7, 7, 8'h32);
        nchk++; if (r_merged != 0 || r_conn != 1 || r_root != 7 || r_size != 1 || r_comp != 12) begin nfail++; $display("FAIL self union: got merged %0d conn %0d root %0d size %0d comp %0d required 0/1/7/1/12", r_merged, r_conn, r_root, r_size, r_comp); end
        cmd(1, 5, 6, 8'h33);
        nchk++; if (r_conn != 0) begin nfail++; $display("FAIL connected(5,6): got %0d required 0", r_conn); end
    endtask

    task automatic test_error_hold();
        int bad = 0;
        issue(3, 2, 3, 8'h5A);
        nchk++; if (lat != 1) begin nfail++; $display("FAIL error latency: got %0d required 1", lat); end
        nchk++; if (r_err != 1 || r_merged != 0 || r_tag != 8'h5A) begin nfail++; $display("FAIL error fields: got err %0d merged %0d tag %0h required 1/0/5a", r_err, r_merged, r_tag); end
        nchk++; if (r_comp != 12 || r_max != 5) begin nfail++; $display("FAIL error counts: got %0d/%0d required 12/5", r_comp, r_max); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nchk++;
            if (a_out_valid !== 1'b1 || a_tag !== 8'h5A || a_err !== 1'b1 || a_in_ready !== 1'b0) begin
                nfail++; bad++;
                $display("FAIL response hold cycle %0d: got valid %b tag %0h err %b ready %b required 1/5a/1/0", c, a_out_valid, a_tag, a_err, a_in_ready);
            end
        end
        ack();
        nchk++; if (a_in_ready !== 1'b1) begin nfail++; $display("FAIL ready after handshake: got %b required 1", a_in_ready); end
    endtask

    task automatic test_random();
        int op, k, u, v, tg;
        for (int t = 0; t < 120; t++) begin
            k  = $urandom_range(0, 9);
            op = (k < 5) ? 0 : (k < 7) ? 1 : (k < 9) ? 2 : 3;
            u  = $urandom_range(0, 15);
            v  = $urandom_range(0, 15);
            tg = $urandom_range(0, 255);
            cmd(op, u, v, tg);
            nchk++; if (r_err != e_err || r_merged != e_merged || r_conn != e_conn) begin nfail++; $display("FAIL random %0d op %0d (%0d,%0d) flags: got %0d%0d%0d required %0d%0d%0d", t, op, u, v, r_err, r_merged, r_conn, e_err, e_merged, e_conn); end
            nchk++; if (r_root != e_root || r_size != e_size) begin nfail++; $display("FAIL random %0d op %0d (%0d,%0d) root/size: got %0d/%0d required %0d/%0d", t, op, u, v, r_root, r_size, e_root, e_size); end
            nchk++; if (r_tag != tg) begin nfail++; $display("FAIL random %0d tag: got %0h required %0h", t, r_tag, tg); end
            nchk++; if (r_comp != m_comp || r_max != m_max) begin nfail++; $display("FAIL random %0d counts: got %0d/%0d required %0d/%0d", t, r_comp, r_max, m_comp, m_max); end
        end
    endtask

    task automatic test_depth_latency();
        sel = 1'b1;
        cmd(0, 0, 1, 1); cmd(0, 2, 3, 2); cmd(0, 0, 2, 3);
        cmd(0, 4, 5, 4); cmd(0, 6, 7, 5); cmd(0, 4, 6, 6); cmd(0, 0, 4, 7);
        nchk++; if (r_root != 0 || r_size != 8 || r_comp != 5 || r_max != 8) begin nfail++; $display("FAIL tree build: got root %0d size %0d comp %0d max %0d required 0/8/5/8", r_root, r_size, r_comp, r_max); end
        cmd(2, 7, 0, 8'h77);
        nchk++; if (lat != LAT_DEEP) begin nfail++; $display("FAIL depth-3 size_of latency: got %0d required %0d", lat, LAT_DEEP); end
        nchk++; if (r_size != 8 || r_root != 0 || r_conn != 1) begin nfail++; $display("FAIL depth-3 size_of: got size %0d root %0d conn %0d required 8/0/1", r_size, r_root, r_conn); end
    endtask

    task automatic test_range();
        sel = 1'b1;
        cmd(0, 13, 0, 8'h41);
        nchk++; if (r_err != 1 || lat != 1 || r_comp != 5) begin nfail++; $display("FAIL u out of range: got err %0d lat %0d comp %0d required 1/1/5", r_err, lat, r_comp); end
        cmd(1, 0, 12, 8'h42);
        nchk++; if (r_err != 1) begin nfail++; $display("FAIL v out of range: got %0d required 1", r_err); end
        cmd(2, 8, 15, 8'h43);
        nchk++; if (r_err != 0 || r_size != 1 || r_root != 8) begin nfail++; $display("FAIL size_of ignores v: got err %0d size %0d root %0d required 0/1/8", r_err, r_size, r_root); end
        cmd(0, 11, 8, 8'h44);
        nchk++; if (r_err != 0 || r_merged != 1 || r_root != 11 || r_comp != 4) begin nfail++; $display("FAIL last node union: got err %0d merged %0d root %0d comp %0d required 0/1/11/4", r_err, r_merged, r_root, r_comp); end
    endtask

    task automatic test_reset_mid_find();
        int n = 0, seen = 0;
        sel = 1'b1;
        wait_ready();
        in_op = 2'd2; in_u = 4'd7; in_v = 4'd0; in_tag = 8'h99; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        nchk++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin nfail++; $display("FAIL abort in reset: got valid %b ready %b required 0/0", b_out_valid, b_in_ready); end
        nchk++; if (b_comp !== 4'd12 || b_max !== 4'd1) begin nfail++; $display("FAIL abort counts: got %0d/%0d required 12/1", b_comp, b_max); end
        rst_b = 1'b0;
        while (b_in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
            if (b_out_valid === 1'b1) seen++;
        end
        nchk++; if (n != 12 || seen != 0) begin nfail++; $display("FAIL re-init: got %0d cycles %0d responses required 12/0", n, seen); end
        cmd(2, 7, 0, 8'h9A);
        nchk++; if (r_size != 1 || r_root != 7 || r_comp != 12) begin nfail++; $display("FAIL post-abort size_of: got size %0d root %0d comp %0d required 1/7/12", r_size, r_root, r_comp); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_u = '0; in_v = '0; in_tag = '0;
        @(posedge clk); #1;
        test_reset();
        test_union_basic();
        test_chain();
        test_already_joined();
        test_error_hold();
        test_random();
        test_depth_latency();
        test_range();
        test_reset_mid_find();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
